// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART frame transmitter and its matching receiver.
//   tx_state_e         : frame FSM state encoding
//   DefaultClksPerBit  : clock cycles per bit for 10 MHz / 115200 baud
//   even_parity()      : XOR of a byte, used as the even-parity bit
package uart_frame_tx_pkg;

    localparam int unsigned DefaultClksPerBit = 87;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Byte-stream handshake and serial-side status of the UART frame transmitter.
//   master : producer side (drives tx_data/tx_valid, observes the rest)
//   slave  : transmitter side
interface uart_frame_tx_if;

    logic [7:0] tx_data;        // byte to send, sampled only on acceptance
    logic       tx_valid;       // producer offers tx_data
    logic       tx_ready;       // transmitter can accept a byte this cycle
    logic       tx_serial_out;  // serial line, idle high
    logic       tx_busy;        // a frame is in progress
    logic       frame_done;     // pulse in the last cycle of the stop bit

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_serial_out,
        input  tx_busy,
        input  frame_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_serial_out,
        output tx_busy,
        output frame_done
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and asserts tick in the last
// cycle of each bit period; clear holds the count at zero.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : force count to zero on the next edge
//   tick  : high while the count equals CLKS_PER_BIT-1
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, 8 data bits LSB first, optional even
// parity, one stop bit. Accepts one byte per frame through a valid/ready
// handshake; ready only in IDLE, so a held tx_valid gives exactly one idle
// cycle between frames.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, aborts any frame in progress
//   bus : uart_frame_tx_if.slave (tx_data, tx_valid, tx_ready,
//         tx_serial_out, tx_busy, frame_done)
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    uart_frame_tx_if.slave  bus
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       parity_q, parity_d;
    logic       serial_q, serial_d;
    logic       tick;

    // Counter held at zero in IDLE, so every frame starts a fresh bit period.
    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

    assign bus.tx_ready      = (state_q == StIdle);
    assign bus.tx_busy       = (state_q != StIdle);
    assign bus.tx_serial_out = serial_q;
    assign bus.frame_done    = (state_q == StStop) && tick;

    // serial_d is the line value for the first cycle of the next state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        serial_d = serial_q;
        case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (bus.tx_valid) begin
                    shift_d  = bus.tx_data;
                    parity_d = even_parity(bus.tx_data);
                    serial_d = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    serial_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                    idx_d    = 3'd0;
                    state_d  = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        if (PARITY_EN) begin
                            serial_d = parity_q;
                            state_d  = StParity;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = StStop;
                        end
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    serial_d = 1'b1;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    serial_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                serial_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= 8'h00;
            idx_q    <= 3'd0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three instances (4 clk/bit no parity,
// 4 clk/bit even parity, 87 clk/bit no parity) sharing clock and reset.
// Per-cycle vectors are {tx_serial_out, frame_done, tx_busy, tx_ready}.
module tb_uart_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_frame_tx_if bus0 ();
    uart_frame_tx_if bus1 ();
    uart_frame_tx_if bus2 ();

    uart_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    uart_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    uart_frame_tx #(.CLKS_PER_BIT(87), .PARITY_EN(1'b0)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    logic [3:0]  got;
    logic [3:0]  exp_v;

    // Expected line level k cycles after START entry (k = 0 is first START cycle).
    function automatic logic exp_line(input logic [7:0] d, input bit par, input int cpb,
                                      input int k);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Offer one byte for a single cycle; the instance must be idle.
    task automatic start0(input logic [7:0] d);
        @(posedge clk); #1;
        bus0.tx_data = d; bus0.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus0.tx_valid = 1'b0;
    endtask

    task automatic start1(input logic [7:0] d);
        @(posedge clk); #1;
        bus1.tx_data = d; bus1.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus1.tx_valid = 1'b0;
    endtask

    task automatic start2(input logic [7:0] d);
        @(posedge clk); #1;
        bus2.tx_data = d; bus2.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus2.tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL reset_dut0 got %b exp %b", got, 4'b1001);
        end
        got = {bus1.tx_serial_out, bus1.frame_done, bus1.tx_busy, bus1.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL reset_dut1 got %b exp %b", got, 4'b1001);
        end
        got = {bus2.tx_serial_out, bus2.frame_done, bus2.tx_busy, bus2.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL reset_dut2 got %b exp %b", got, 4'b1001);
        end
        // Reset and valid in the same cycle: reset wins, nothing accepted.
        @(posedge clk); #1;
        rst = 1'b1; bus0.tx_data = 8'hA5; bus0.tx_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus0.tx_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== 4'b1001) begin
                err_cnt++; $display("FAIL reset_vs_valid k=%0d got %b exp %b", k, got, 4'b1001);
            end
        end
    endtask

    task automatic test_single_byte;
        start0(8'hA5);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'hA5, 1'b0, 4, k), (k == 39), 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL single_a5 k=%0d got %b exp %b", k, got, exp_v);
            end
        end
        @(negedge clk);
        got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL single_a5_idle got %b exp %b", got, 4'b1001);
        end
    endtask

    task automatic test_parity;
        logic [7:0] bytes [2];
        bytes[0] = 8'h80;
        bytes[1] = 8'h03;
        for (int n = 0; n < 2; n++) begin
            start1(bytes[n]);
            for (int k = 0; k < 44; k++) begin
                @(negedge clk);
                exp_v = {exp_line(bytes[n], 1'b1, 4, k), (k == 43), 1'b1, 1'b0};
                got   = {bus1.tx_serial_out, bus1.frame_done, bus1.tx_busy, bus1.tx_ready};
                vec_cnt++;
                if (got !== exp_v) begin
                    err_cnt++;
                    $display("FAIL parity_%h k=%0d got %b exp %b", bytes[n], k, got, exp_v);
                end
            end
            @(negedge clk);
            got = {bus1.tx_serial_out, bus1.frame_done, bus1.tx_busy, bus1.tx_ready};
            vec_cnt++;
            if (got !== 4'b1001) begin
                err_cnt++; $display("FAIL parity_%h_idle got %b exp %b", bytes[n], got, 4'b1001);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        bus0.tx_data = 8'h00; bus0.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus0.tx_data = 8'hFF;  // valid stays high
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'h00, 1'b0, 4, k), (k == 39), 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL b2b_first k=%0d got %b exp %b", k, got, exp_v);
            end
        end
        @(negedge clk);
        got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL b2b_gap got %b exp %b", got, 4'b1001);
        end
        @(posedge clk); #1;
        bus0.tx_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'hFF, 1'b0, 4, k), (k == 39), 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL b2b_second k=%0d got %b exp %b", k, got, exp_v);
            end
        end
        @(negedge clk);
        got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL b2b_end got %b exp %b", got, 4'b1001);
        end
    endtask

    task automatic test_ignore_midframe;
        start0(8'h3C);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'h3C, 1'b0, 4, k), (k == 39), 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL midframe k=%0d got %b exp %b", k, got, exp_v);
            end
            if (k == 10) begin
                bus0.tx_data = 8'hFF; bus0.tx_valid = 1'b1;
            end
            if (k == 14) begin
                bus0.tx_valid = 1'b0;
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== 4'b1001) begin
                err_cnt++; $display("FAIL midframe_idle k=%0d got %b exp %b", k, got, 4'b1001);
            end
        end
    endtask

    task automatic test_reset_midframe;
        start0(8'hC3);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'hC3, 1'b0, 4, k), 1'b0, 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL rst_mid_pre k=%0d got %b exp %b", k, got, exp_v);
            end
        end
        rst = 1'b1;  // during data bit 3
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            got = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== 4'b1001) begin
                err_cnt++; $display("FAIL rst_mid_post k=%0d got %b exp %b", k, got, 4'b1001);
            end
        end
        start0(8'h5A);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'h5A, 1'b0, 4, k), (k == 39), 1'b1, 1'b0};
            got   = {bus0.tx_serial_out, bus0.frame_done, bus0.tx_busy, bus0.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL rst_mid_5a k=%0d got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_long_baud;
        start2(8'h55);
        for (int k = 0; k < 870; k++) begin
            @(negedge clk);
            exp_v = {exp_line(8'h55, 1'b0, 87, k), (k == 869), 1'b1, 1'b0};
            got   = {bus2.tx_serial_out, bus2.frame_done, bus2.tx_busy, bus2.tx_ready};
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL baud87 k=%0d got %b exp %b", k, got, exp_v);
            end
        end
        @(negedge clk);
        got = {bus2.tx_serial_out, bus2.frame_done, bus2.tx_busy, bus2.tx_ready};
        vec_cnt++;
        if (got !== 4'b1001) begin
            err_cnt++; $display("FAIL baud87_idle got %b exp %b", got, 4'b1001);
        end
    endtask

    initial begin
        bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0;
        bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0;
        bus2.tx_data = 8'h00; bus2.tx_valid = 1'b0;
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_long_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
